// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD operand path: FSM states, digit width and
// active-low seven-segment patterns (bit 6 = segment a ... bit 0 = segment g).
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One BCD digit's double-dabble correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// valid/ready on both sides. Optional seven-segment output with BIN2BCD_SEG_EN.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_W-1:0]       in_bin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BCD_W*DIGITS-1:0] out_bcd,
  output logic                   out_ovf
`ifdef BIN2BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]    out_seg
`endif
);

  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int BCD_TOT = BCD_W * DIGITS;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_TOT-1:0] bcd_q;
  logic [BCD_TOT-1:0] bcd_adj;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit (bcd_q[BCD_W*k +: BCD_W]),
      .adj   (bcd_adj[BCD_W*k +: BCD_W])
    );
  end

  assign accept = (state_q == ST_IDLE) && in_valid;

  always_comb begin
    // NOTE: default assigned first so no branch leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)            state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(1))  state_d = ST_DONE;
      ST_DONE:  if (out_ready)           state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The bit leaving the top corrected digit is a lost decade: sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      bin_q <= in_bin;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= CNT_W'(BIN_W);
    end else if (state_q == ST_SHIFT) begin
      bcd_q <= {bcd_adj[BCD_TOT-2:0], bin_q[BIN_W-1]};
      bin_q <= bin_q << 1;
      ovf_q <= ovf_q | bcd_adj[BCD_TOT-1];
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_bcd   = bcd_q;
  assign out_ovf   = ovf_q;

`ifdef BIN2BCD_SEG_EN
  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    assign out_seg[7*k +: 7] = ovf_q ? SEG_BLANK : seg_decode(bcd_q[BCD_W*k +: BCD_W]);
  end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: a 3-digit and a 2-digit converter driven in lockstep,
// results compared against a decimal reference computed with / and %.
module tb_bin2bcd_seq;

  localparam int BIN_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_bin = '0;

  logic        in_ready3, out_valid3, ovf3;
  logic [11:0] bcd3;
  logic        in_ready2, out_valid2, ovf2;
  logic [7:0]  bcd2;
`ifdef BIN2BCD_SEG_EN
  logic [20:0] seg3;
  logic [13:0] seg2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0001100};

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_bin(in_bin), .out_valid(out_valid3), .out_ready(out_ready),
    .out_bcd(bcd3), .out_ovf(ovf3)
`ifdef BIN2BCD_SEG_EN
    , .out_seg(seg3)
`endif
  );

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_bin(in_bin), .out_valid(out_valid2), .out_ready(out_ready),
    .out_bcd(bcd2), .out_ovf(ovf2)
`ifdef BIN2BCD_SEG_EN
    , .out_seg(seg2)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] ref_bcd(input int v, input int digits);
    logic [11:0] r = '0;
    int x = v;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int digits);
    int lim = 1;
    for (int k = 0; k < digits; k++) lim = lim * 10;
    return v >= lim;
  endfunction

  function automatic logic [20:0] ref_seg(input int v, input int digits);
    logic [20:0] s = '0;
    logic [11:0] b = ref_bcd(v, digits);
    for (int k = 0; k < digits; k++)
      s[7*k +: 7] = ref_ovf(v, digits) ? 7'b1111111 : seg_tab[b[4*k +: 4]];
    return s;
  endfunction

  // One full transaction: accept, wait for result, optional hold, release.
  task automatic convert(input int v, input int hold);
    int lat;
    logic [11:0] e3;
    logic [7:0]  e2;
    logic        o2;
    e3 = ref_bcd(v, 3);
    e2 = 8'(ref_bcd(v, 2));
    o2 = ref_ovf(v, 2);
    @(negedge clk);
    n_cmp++;
    if (in_ready3 !== 1'b1 || in_ready2 !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_ready v=%0d: got %b/%b want 1/1", v, in_ready3, in_ready2);
    end
    in_valid = 1'b1;
    in_bin   = v[7:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid3 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (lat != BIN_W) begin
      n_bad++;
      $display("FAIL latency v=%0d: got %0d want %0d", v, lat, BIN_W);
    end
    n_cmp++;
    if (out_valid2 !== 1'b1) begin
      n_bad++;
      $display("FAIL valid2 v=%0d: got %b want 1", v, out_valid2);
    end
    n_cmp++;
    if (bcd3 !== e3 || ovf3 !== 1'b0) begin
      n_bad++;
      $display("FAIL bcd3 v=%0d: got %h ovf %b want %h ovf 0", v, bcd3, ovf3, e3);
    end
    n_cmp++;
    if (bcd2 !== e2 || ovf2 !== o2) begin
      n_bad++;
      $display("FAIL bcd2 v=%0d: got %h ovf %b want %h ovf %b", v, bcd2, ovf2, e2, o2);
    end
`ifdef BIN2BCD_SEG_EN
    n_cmp++;
    if (seg3 !== ref_seg(v, 3) || seg2 !== 14'(ref_seg(v, 2))) begin
      n_bad++;
      $display("FAIL seg v=%0d: got %b %b want %b %b", v, seg3, seg2,
               ref_seg(v, 3), 14'(ref_seg(v, 2)));
    end
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_bin   = 8'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid3 !== 1'b1 || bcd3 !== e3 || bcd2 !== e2 || ovf2 !== o2 || in_ready3 !== 1'b0) begin
        n_bad++;
        $display("FAIL hold v=%0d cyc=%0d: valid %b bcd %h/%h ovf2 %b rdy %b want 1 %h/%h %b 0",
                 v, i, out_valid3, bcd3, bcd2, ovf2, in_ready3, e3, e2, o2);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0 || in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
      n_bad++;
      $display("FAIL release v=%0d: rdy %b/%b valid %b/%b want 1/1 0/0",
               v, in_ready3, in_ready2, out_valid3, out_valid2);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0 || bcd3 !== 12'h000 || ovf3 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset3: rdy %b valid %b bcd %h ovf %b want 1 0 000 0",
               in_ready3, out_valid3, bcd3, ovf3);
    end
    n_cmp++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || bcd2 !== 8'h00 || ovf2 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset2: rdy %b valid %b bcd %h ovf %b want 1 0 00 0",
               in_ready2, out_valid2, bcd2, ovf2);
    end
`ifdef BIN2BCD_SEG_EN
    n_cmp++;
    if (seg3 !== {3{7'b0000001}}) begin
      n_bad++;
      $display("FAIL reset_seg: got %b want %b", seg3, {3{7'b0000001}});
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    convert(0, 0);
    convert(255, 0);
    convert(99, 0);
    convert(100, 0);
    convert(9, 1);
  endtask

  task automatic test_backpressure();
    convert(123, 20);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = 8'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0 || bcd3 !== 12'h000 || ovf3 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: rdy %b valid %b bcd %h ovf %b want 1 0 000 0",
               in_ready3, out_valid3, bcd3, ovf3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    convert(37, 0);
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 256; v++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      convert(v, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
